// File: rtl/mem_stage.sv
// Purpose : MEM pipeline stage. Registers the EX bus, extracts load data from SRAM
//           read data and drives the write-back and ID forwarding buses.
// Latency : one cycle from ex_to_mem_bus to both output buses; load data is taken
//           live in the first MEM cycle.
// Backpressure: stall[3]/stall[4] hold or bubble the stage register; while a load
//           is held the first-cycle read data is kept in rdata_hold.
// Ports   : clk, resetn (async active-low), stall[5:0], ex_to_mem_bus,
//           data_sram_rdata, mem_to_wb_bus, mem_to_id_bus, load_busy.
module mem_stage #(
  parameter int EX_TO_MEM_WD = 146,
  parameter int MEM_TO_WB_WD = 136,
  parameter int MEM_TO_ID_WD = 104
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [5:0]              stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus,
  output logic                    load_busy
);

  localparam logic [3:0] LC_LW  = 4'b1111;
  localparam logic [3:0] LC_LB  = 4'b0001;
  localparam logic [3:0] LC_LBU = 4'b0010;
  localparam logic [3:0] LC_LH  = 4'b0011;
  localparam logic [3:0] LC_LHU = 4'b0100;

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  logic [EX_TO_MEM_WD-1:0] ex_q;
  state_t                  state_q, state_d;
  logic                    hold_cap;
  logic [31:0]             rdata_hold;

  // Stage register fields
  logic [3:0]  load_code;
  logic        hi_we, lo_we;
  logic [31:0] hi, lo, pc;
  logic        ram_en;
  logic [3:0]  ram_wen;
  logic        sel_rf_res, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] ex_result;

  assign {load_code, hi_we, lo_we, hi, lo, pc,
          ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result} = ex_q[145:0];

  // Store-side controls were already issued to the SRAM in EX; nothing left to do here.
  logic unused_bits;
  assign unused_bits = ^{stall[5], stall[2:0], ram_en, ram_wen};

  // The register only holds when both the EX/MEM and MEM/WB boundaries stop.
  logic reg_hold;
  assign reg_hold = stall[3] && stall[4];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex_q <= '0;
    end else if (stall[3] && !stall[4]) begin
      ex_q <= '0;
    end else if (!stall[3]) begin
      ex_q <= ex_to_mem_bus;
    end
  end

  logic is_load;
  assign is_load = (load_code == LC_LW)  || (load_code == LC_LB) ||
                   (load_code == LC_LBU) || (load_code == LC_LH) ||
                   (load_code == LC_LHU);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // SRAM data is only valid for one cycle; a held load must keep what it saw then.
  always_comb begin
    state_d  = state_q;
    hold_cap = 1'b0;
    if (!reg_hold) begin
      state_d = S_IDLE;
    end else if (state_q == S_IDLE && is_load) begin
      state_d  = S_HOLD;
      hold_cap = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_hold <= '0;
    end else if (hold_cap) begin
      rdata_hold <= data_sram_rdata;
    end
  end

  logic [31:0] data_src;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_data;
  logic [31:0] wb_result;

  assign data_src = (state_q == S_HOLD) ? rdata_hold : data_sram_rdata;

  always_comb begin
    sel_byte  = data_src[7:0];
    sel_half  = ex_result[1] ? data_src[31:16] : data_src[15:0];
    load_data = data_src;
    case (ex_result[1:0])
      2'd0: sel_byte = data_src[7:0];
      2'd1: sel_byte = data_src[15:8];
      2'd2: sel_byte = data_src[23:16];
      default: sel_byte = data_src[31:24];
    endcase
    case (load_code)
      LC_LB:  load_data = {{24{sel_byte[7]}}, sel_byte};
      LC_LBU: load_data = {24'h0, sel_byte};
      LC_LH:  load_data = {{16{sel_half[15]}}, sel_half};
      LC_LHU: load_data = {16'h0, sel_half};
      default: load_data = data_src;
    endcase
  end

  assign wb_result = (sel_rf_res && is_load) ? load_data : ex_result;
  assign load_busy = (state_q == S_IDLE) && is_load;

  assign mem_to_wb_bus = {hi_we, lo_we, hi, lo, pc, rf_we, rf_waddr, wb_result};
  assign mem_to_id_bus = {rf_we, rf_waddr, wb_result, hi_we, lo_we, hi, lo};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios followed by randomized traffic, every
// cycle compared against a reference model that tracks the instruction in MEM,
// how many cycles it has waited there, and the read data it saw in its first cycle.
module tb_mem_stage;

  logic         clk;
  logic         resetn;
  logic [5:0]   stall;
  logic [145:0] ex_to_mem_bus;
  logic [31:0]  data_sram_rdata;
  logic [135:0] mem_to_wb_bus;
  logic [103:0] mem_to_id_bus;
  logic         load_busy;

  mem_stage dut (
    .clk            (clk),
    .resetn         (resetn),
    .stall          (stall),
    .ex_to_mem_bus  (ex_to_mem_bus),
    .data_sram_rdata(data_sram_rdata),
    .mem_to_wb_bus  (mem_to_wb_bus),
    .mem_to_id_bus  (mem_to_id_bus),
    .load_busy      (load_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  lc;
    logic        hi_we, lo_we;
    logic [31:0] hi, lo, pc;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        sel, rf_we;
    logic [4:0]  waddr;
    logic [31:0] exres;
  } ex_t;

  int total = 0;
  int bad   = 0;

  // Reference model state
  ex_t         m_e;
  int          m_age;
  logic [31:0] m_first;
  logic [5:0]  cur_s;
  ex_t         cur_e;
  logic [31:0] cur_r;
  ex_t         nop;

  function automatic logic [145:0] pack(input ex_t e);
    return {e.lc, e.hi_we, e.lo_we, e.hi, e.lo, e.pc, e.ram_en, e.ram_wen,
            e.sel, e.rf_we, e.waddr, e.exres};
  endfunction

  function automatic ex_t zero_instr();
    ex_t e;
    e = '{default: 0};
    return e;
  endfunction

  function automatic ex_t mk(input logic [3:0] lc, input logic sel, input logic [31:0] exres);
    ex_t e;
    e.lc = lc; e.hi_we = 1'b1; e.lo_we = 1'b0;
    e.hi = 32'hA5A5_0001; e.lo = 32'h5A5A_0002; e.pc = 32'hBFC0_0100;
    e.ram_en = 1'b1; e.ram_wen = 4'h0; e.sel = sel; e.rf_we = 1'b1;
    e.waddr = 5'd9; e.exres = exres;
    return e;
  endfunction

  function automatic ex_t rand_instr();
    ex_t e;
    int k;
    k = $urandom_range(0, 9);
    case (k)
      0: e.lc = 4'b1111;
      1: e.lc = 4'b0001;
      2: e.lc = 4'b0010;
      3: e.lc = 4'b0011;
      4: e.lc = 4'b0100;
      5: e.lc = 4'b0101;
      6: e.lc = 4'b0111;
      7: e.lc = 4'b0000;
      default: e.lc = 4'($urandom);
    endcase
    e.hi_we = 1'($urandom); e.lo_we = 1'($urandom);
    e.hi = $urandom; e.lo = $urandom; e.pc = $urandom;
    e.ram_en = 1'($urandom); e.ram_wen = 4'($urandom);
    e.sel = ($urandom_range(0, 3) != 0); e.rf_we = 1'($urandom);
    e.waddr = 5'($urandom); e.exres = $urandom;
    return e;
  endfunction

  function automatic bit is_load(input logic [3:0] lc);
    return lc == 4'd15 || lc == 4'd1 || lc == 4'd2 || lc == 4'd3 || lc == 4'd4;
  endfunction

  // Load value from the read-data word by shifting and masking.
  function automatic logic [31:0] exp_wb(input ex_t e, input logic [31:0] d);
    logic [31:0] v;
    if (!e.sel || !is_load(e.lc)) return e.exres;
    case (e.lc)
      4'd1, 4'd2: begin
        v = (d >> (8 * e.exres[1:0])) & 32'hFF;
        if (e.lc == 4'd1 && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end
      4'd3, 4'd4: begin
        v = (d >> (16 * e.exres[1])) & 32'hFFFF;
        if (e.lc == 4'd3 && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end
      default: v = d;
    endcase
    return v;
  endfunction

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    logic [31:0]  d, w;
    logic [135:0] ewb;
    logic [103:0] eid;
    d   = (m_age == 0) ? cur_r : m_first;
    w   = exp_wb(m_e, d);
    ewb = {m_e.hi_we, m_e.lo_we, m_e.hi, m_e.lo, m_e.pc, m_e.rf_we, m_e.waddr, w};
    eid = {m_e.rf_we, m_e.waddr, w, m_e.hi_we, m_e.lo_we, m_e.hi, m_e.lo};
    chk("model_wb_bus", mem_to_wb_bus, ewb);
    chk("model_id_bus", {32'h0, mem_to_id_bus}, {32'h0, eid});
    chk("model_load_busy", 136'(load_busy), 136'(is_load(m_e.lc) && m_age == 0));
  endtask

  task automatic model_reset();
    m_e = zero_instr();
    m_age = 0;
    m_first = 32'h0;
  endtask

  task automatic drive(input logic [5:0] s, input ex_t e, input logic [31:0] r);
    stall = s; ex_to_mem_bus = pack(e); data_sram_rdata = r;
    cur_s = s; cur_e = e; cur_r = r;
    #1;
    model_check();
  endtask

  task automatic clk_edge();
    @(posedge clk);
    if (cur_s[3] && !cur_s[4]) begin
      m_e = zero_instr(); m_age = 0;
    end else if (!cur_s[3]) begin
      m_e = cur_e; m_age = 0;
    end else begin
      if (m_age == 0) m_first = cur_r;
      if (m_age < 1000) m_age++;
    end
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wb"}, mem_to_wb_bus, 136'h0);
    chk({tag, "_id"}, {32'h0, mem_to_id_bus}, 136'h0);
    chk({tag, "_busy"}, 136'(load_busy), 136'h0);
  endtask

  initial begin
    nop = mk(4'b0000, 1'b0, 32'h0);
    model_reset();
    resetn = 1'b0;
    stall = 6'b0; ex_to_mem_bus = pack(rand_instr()); data_sram_rdata = $urandom;
    #3;
    chk_all_zero("reset_async");
    @(posedge clk); #1;
    chk_all_zero("reset_edge");
    #2 resetn = 1'b1;

    // Idle after reset until the first capture
    drive(6'b011111, rand_instr(), $urandom);
    chk_all_zero("post_reset");
    clk_edge();
    drive(6'b011111, rand_instr(), $urandom);
    chk_all_zero("post_reset_held");
    clk_edge();

    // LB, byte 3, sign-extended
    drive(6'b0, mk(4'b0001, 1'b1, 32'h1003), 32'h0);
    clk_edge();
    drive(6'b0, nop, 32'h80FF_1234);
    chk("lb_wb", 136'(mem_to_wb_bus[31:0]), 136'hFFFF_FF80);
    chk("lb_rf_we", 136'(mem_to_wb_bus[37]), 136'h1);
    chk("lb_busy", 136'(load_busy), 136'h1);
    clk_edge();

    // LHU then LH on the high half
    drive(6'b0, mk(4'b0100, 1'b1, 32'h2002), 32'h0);
    clk_edge();
    drive(6'b0, mk(4'b0011, 1'b1, 32'h2002), 32'h9ABC_5678);
    chk("lhu_wb", 136'(mem_to_wb_bus[31:0]), 136'h0000_9ABC);
    clk_edge();
    drive(6'b0, nop, 32'h9ABC_5678);
    chk("lh_wb", 136'(mem_to_wb_bus[31:0]), 136'hFFFF_9ABC);
    clk_edge();

    // LW held for three cycles while rdata moves on
    drive(6'b0, mk(4'b1111, 1'b1, 32'h40), 32'h0);
    clk_edge();
    drive(6'b011111, nop, 32'h1122_3344);
    chk("lw_hold_c1", 136'(mem_to_wb_bus[31:0]), 136'h1122_3344);
    chk("lw_hold_busy_c1", 136'(load_busy), 136'h1);
    clk_edge();
    for (int i = 0; i < 3; i++) begin
      drive((i < 2) ? 6'b011111 : 6'b000000, nop, 32'hDEAD_BEEF);
      chk("lw_hold_cn", 136'(mem_to_wb_bus[31:0]), 136'h1122_3344);
      chk("lw_hold_busy_cn", 136'(load_busy), 136'h0);
      clk_edge();
    end

    // Bubble out of HOLD, then a fresh load sees live data
    drive(6'b0, mk(4'b1111, 1'b1, 32'h80), 32'h0);
    clk_edge();
    drive(6'b011111, nop, 32'hAAAA_5555);
    clk_edge();
    drive(6'b001111, nop, 32'h0);
    chk("hold_before_bubble", 136'(mem_to_wb_bus[31:0]), 136'hAAAA_5555);
    clk_edge();
    drive(6'b0, mk(4'b1111, 1'b1, 32'hC0), 32'h0BAD_F00D);
    chk_all_zero("bubble");
    clk_edge();
    drive(6'b011111, nop, 32'h600D_600D);
    chk("after_bubble_live", 136'(mem_to_wb_bus[31:0]), 136'h600D_600D);
    chk("after_bubble_busy", 136'(load_busy), 136'h1);
    clk_edge();

    // Non-loads pass ex_result regardless of rdata
    drive(6'b0, mk(4'b0000, 1'b0, 32'h1234_5678), 32'h0);
    clk_edge();
    drive(6'b0, mk(4'b0101, 1'b1, 32'hCAFE_0001), $urandom);
    chk("alu_wb", 136'(mem_to_wb_bus[31:0]), 136'h1234_5678);
    clk_edge();
    drive(6'b0, nop, $urandom);
    chk("sb_wb", 136'(mem_to_wb_bus[31:0]), 136'hCAFE_0001);
    chk("sb_busy", 136'(load_busy), 136'h0);
    clk_edge();

    // Asynchronous reset while holding a load
    drive(6'b0, mk(4'b1111, 1'b1, 32'h100), 32'h0);
    clk_edge();
    drive(6'b011111, nop, 32'h1357_2468);
    clk_edge();
    drive(6'b011111, nop, 32'hFFFF_0000);
    chk("pre_reset_hold", 136'(mem_to_wb_bus[31:0]), 136'h1357_2468);
    resetn = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    model_reset();
    #2 resetn = 1'b1;
    drive(6'b0, mk(4'b1111, 1'b1, 32'h104), 32'h0);
    clk_edge();
    drive(6'b0, nop, 32'h2468_1357);
    chk("post_reset_live", 136'(mem_to_wb_bus[31:0]), 136'h2468_1357);
    chk("post_reset_busy", 136'(load_busy), 136'h1);
    clk_edge();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [5:0] s;
      int k;
      k = $urandom_range(0, 7);
      if (k <= 3)      s = 6'b000000;
      else if (k == 4) s = 6'b001111;
      else if (k <= 6) s = 6'b011000 | 6'($urandom_range(0, 7)) | 6'($urandom_range(0, 1) << 5);
      else             s = 6'($urandom);
      drive(s, rand_instr(), $urandom);
      clk_edge();
    end
    drive(6'b0, nop, $urandom);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
